// File: rtl/tt_lut_seq.sv
// Programmable truth-table block: N_IN inputs, N_OUT outputs, flop-based table
// with single-vector eval, serial table reload and a full-table sweep.
module tt_lut_seq #(
   parameter int unsigned               N_IN    = 3,
   parameter int unsigned               N_OUT   = 1,
   parameter logic [N_OUT*(2**N_IN)-1:0] TT_INIT = 8'h55
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_IN-1:0]  in_bits,
   input  logic             in_valid,
   output logic [N_OUT-1:0] out_bits,
   output logic             out_valid,
   output logic [N_IN-1:0]  sweep_row,
   input  logic             load_start,
   input  logic             load_valid,
   input  logic [N_OUT-1:0] load_data,
   output logic             load_ready,
   input  logic             sweep_start,
   output logic             sweep_done,
   output logic             busy
);

   localparam int unsigned ROWS = 2**N_IN;
   localparam int unsigned CW   = N_IN + 1;
   localparam logic [CW-1:0] LAST_ROW = CW'(ROWS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SWEEP = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [N_OUT-1:0] tbl_q [ROWS];
   logic [N_OUT-1:0] out_bits_q, out_bits_d;
   logic             out_valid_q, out_valid_d;
   logic [N_IN-1:0]  sweep_row_q, sweep_row_d;
   logic             load_ready_q, load_ready_d;
   logic             sweep_done_q, sweep_done_d;
   logic             busy_q, busy_d;
   logic             wr_en;
   logic [N_IN-1:0]  rd_idx;

   // Next-state and registered-output computation
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      out_bits_d   = out_bits_q;
      out_valid_d  = 1'b0;
      sweep_row_d  = sweep_row_q;
      sweep_done_d = 1'b0;
      wr_en        = 1'b0;
      rd_idx       = (state_q == SWEEP) ? cnt_q[N_IN-1:0] : in_bits;

      case (state_q)
         IDLE: begin
            if (load_start) begin
               state_d = LOAD;
               cnt_d   = '0;
            end else if (sweep_start) begin
               state_d = SWEEP;
               cnt_d   = '0;
            end else if (in_valid) begin
               out_bits_d  = tbl_q[rd_idx];
               sweep_row_d = in_bits;
               out_valid_d = 1'b1;
            end
         end
         LOAD: begin
            if (load_valid && load_ready_q) begin
               wr_en = 1'b1;
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == LAST_ROW) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end
            end
         end
         SWEEP: begin
            out_bits_d  = tbl_q[rd_idx];
            sweep_row_d = cnt_q[N_IN-1:0];
            out_valid_d = 1'b1;
            cnt_d       = cnt_q + CW'(1);
            if (cnt_q == LAST_ROW) begin
               sweep_done_d = 1'b1;
               state_d      = IDLE;
               cnt_d        = '0;
            end
         end
         default: state_d = IDLE;
      endcase

      // Both flags track the state being entered, so they change on the same edge
      load_ready_d = (state_d == LOAD);
      busy_d       = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         out_bits_q   <= '0;
         out_valid_q  <= 1'b0;
         sweep_row_q  <= '0;
         load_ready_q <= 1'b0;
         sweep_done_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         out_bits_q   <= out_bits_d;
         out_valid_q  <= out_valid_d;
         sweep_row_q  <= sweep_row_d;
         load_ready_q <= load_ready_d;
         sweep_done_q <= sweep_done_d;
         busy_q       <= busy_d;
      end
   end

   // Table storage; row 0 lives in the MSBs of TT_INIT
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned r = 0; r < ROWS; r++) begin
            tbl_q[r] <= TT_INIT[(ROWS-1-r)*N_OUT +: N_OUT];
         end
      end else if (wr_en) begin
         tbl_q[cnt_q[N_IN-1:0]] <= load_data;
      end
   end

   assign out_bits   = out_bits_q;
   assign out_valid  = out_valid_q;
   assign sweep_row  = sweep_row_q;
   assign load_ready = load_ready_q;
   assign sweep_done = sweep_done_q;
   assign busy       = busy_q;

endmodule
